// File: rtl/fetch_unit.sv
// fetch_unit
//
// Instruction fetch stage for the 8-bit accumulator CPU. It holds the
// program counter and fetches 16-bit instruction words from instruction
// memory over a req/ack handshake. It latches each word into outins for the
// downstream control unit. It then picks the next PC from the control
// unit's stop / pcJMP / banEBL / ban inputs.
//
// Parameters
//   RESET_PC  PC loaded on reset; first fetch address
//   CNT_W     width of the retired-instruction counter
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset
//   imem_req   read request, held with a stable address until acknowledged
//   imem_addr  read address, always equal to pc
//   imem_ack   memory acknowledge, imem_data valid in the same cycle
//   imem_data  instruction word from memory
//   outins     instruction register ([15:8] opcode, [7:0] operand/target)
//   ins_valid  one-cycle pulse while outins holds a fresh instruction (EXEC)
//   stop       halt request from the control unit
//   pcJMP      unconditional jump from the control unit
//   banEBL     conditional-branch enable from the control unit
//   ban        branch condition (accumulator negative)
//   pc         current program counter
//   halted     high while halted
//   ins_cnt    saturating count of executed instructions

module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  output logic [15:0]      outins,
  output logic             ins_valid,
  input  logic             stop,
  input  logic             pcJMP,
  input  logic             banEBL,
  input  logic             ban,
  output logic [7:0]       pc,
  output logic             halted,
  output logic [CNT_W-1:0] ins_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;

  // The request address is never registered separately, so it cannot
  // drift away from the PC.
  assign imem_addr = pc;

  // Single FSM with registered outputs. imem_req, ins_valid and halted are
  // set on the edge that enters the state they describe, so each one is
  // high exactly while the FSM sits in FETCH, EXEC or HALT respectively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      outins    <= 16'h0000;
      imem_req  <= 1'b0;
      ins_valid <= 1'b0;
      halted    <= 1'b0;
      ins_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem_ack) begin
            outins    <= imem_data;
            imem_req  <= 1'b0;
            ins_valid <= 1'b1;
            state     <= EXEC;
          end
        end

        EXEC: begin
          ins_valid <= 1'b0;
          // The instruction counts as retired on every exit from EXEC,
          // including the exit into HALT.
          if (ins_cnt != CNT_MAX) begin
            ins_cnt <= ins_cnt + CNT_ONE;
          end
          // stop has priority over every PC update, so a halted PC still
          // points at the halting instruction.
          if (stop) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= FETCH;
            if (pcJMP || (banEBL && ban)) begin
              pc <= outins[7:0];
            end else begin
              pc <= pc + 8'd1;
            end
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
